// File: rtl/bouncing_image_source.sv
// Pixel source for the VGA driver: overlays a ROM-backed image on a flat background
// and bounces the image around the active area once per frame during vertical blanking.
module bouncing_image_source #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 48,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STEP        = 1,
  parameter logic [7:0]  BG_COLOR    = 8'h00,
  parameter logic [7:0]  TRANSPARENT = 8'hE3
) (
  input  logic              CLK_IN,
  input  logic              RESET_N,
  input  logic [9:0]        xCoord,
  input  logic [9:0]        yCoord,
  input  logic              MOVE_EN,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        RGB_out,
  output logic              HIT
);

  localparam int unsigned CW = 11;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam logic [CW-1:0] X_MAX   = CW'(H_ACTIVE - IMG_W);
  localparam logic [CW-1:0] Y_MAX   = CW'(V_ACTIVE - IMG_H);
  localparam logic [CW-1:0] STEP_C  = CW'(STEP);
  localparam logic [CW-1:0] IMG_W_C = CW'(IMG_W);
  localparam logic [CW-1:0] IMG_H_C = CW'(IMG_H);

  // dir_*: 0 = moving towards larger coordinates, 1 = towards smaller
  logic [CW-1:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic              in_d1_q, in_d1_d, in_d2_q, in_d2_d;
  logic              cond_prev_q, cond_prev_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        rgb_q, rgb_d;

  logic [CW-1:0]     x_c, y_c, rel_x_c, rel_y_c;
  logic              inside_c, cond_c, tick_c, flip_x_c, flip_y_c;

  // Image-hit test and ROM address for the incoming coordinate
  always_comb begin
    x_c      = {1'b0, xCoord};
    y_c      = {1'b0, yCoord};
    rel_x_c  = x_c - pos_x_q;
    rel_y_c  = y_c - pos_y_q;
    inside_c = (x_c >= pos_x_q) && (x_c < pos_x_q + IMG_W_C) &&
               (y_c >= pos_y_q) && (y_c < pos_y_q + IMG_H_C);
    in_d1_d  = inside_c;
    in_d2_d  = in_d1_q;
    rom_addr_d = '0;
    if (inside_c) begin
      rom_addr_d = (ADDR_W'(rel_y_c) << XW) | ADDR_W'(rel_x_c);
    end
    rgb_d = (in_d2_q && (rom_data != TRANSPARENT)) ? rom_data : BG_COLOR;
  end

  // Once-per-frame tick on the first blanking line, independent of hold length
  always_comb begin
    cond_c      = (xCoord == 10'd0) && (yCoord == 10'(V_ACTIVE));
    tick_c      = cond_c && !cond_prev_q;
    cond_prev_d = cond_c;
  end

  // Bounce motion; positions only change on a tick, which lies outside the active area
  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    flip_x_c = 1'b0;
    flip_y_c = 1'b0;
    hit_d    = 1'b0;
    if (tick_c && MOVE_EN) begin
      if (!dir_x_q) begin
        if (pos_x_q + STEP_C >= X_MAX) begin
          pos_x_d  = X_MAX;
          dir_x_d  = 1'b1;
          flip_x_c = 1'b1;
        end else begin
          pos_x_d = pos_x_q + STEP_C;
        end
      end else begin
        if (pos_x_q <= STEP_C) begin
          pos_x_d  = '0;
          dir_x_d  = 1'b0;
          flip_x_c = 1'b1;
        end else begin
          pos_x_d = pos_x_q - STEP_C;
        end
      end
      if (!dir_y_q) begin
        if (pos_y_q + STEP_C >= Y_MAX) begin
          pos_y_d  = Y_MAX;
          dir_y_d  = 1'b1;
          flip_y_c = 1'b1;
        end else begin
          pos_y_d = pos_y_q + STEP_C;
        end
      end else begin
        if (pos_y_q <= STEP_C) begin
          pos_y_d  = '0;
          dir_y_d  = 1'b0;
          flip_y_c = 1'b1;
        end else begin
          pos_y_d = pos_y_q - STEP_C;
        end
      end
      hit_d = flip_x_c || flip_y_c;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      in_d1_q     <= 1'b0;
      in_d2_q     <= 1'b0;
      cond_prev_q <= 1'b0;
      hit_q       <= 1'b0;
      rom_addr_q  <= '0;
      rgb_q       <= BG_COLOR;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      in_d1_q     <= in_d1_d;
      in_d2_q     <= in_d2_d;
      cond_prev_q <= cond_prev_d;
      hit_q       <= hit_d;
      rom_addr_q  <= rom_addr_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign RGB_out  = rgb_q;
  assign HIT      = hit_q;

endmodule

// File: tb/tb_bouncing_image_source.sv
// Directed bench for bouncing_image_source: pixel pipeline, transparency, bounce and reset.
// A second instance with a narrower active area makes a simultaneous corner hit reachable.
module tb_bouncing_image_source;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  xCoord = 10'd700;
  logic [9:0]  yCoord = 10'd500;
  logic        MOVE_EN = 1'b0;
  logic [11:0] rom_addr, rom_addr_c;
  logic [7:0]  rom_data = 8'h1C;
  logic [7:0]  rom_data_c = 8'h1C;
  logic [7:0]  RGB_out, RGB_out_c;
  logic        HIT, HIT_c;
  logic        rom_mode = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] e0 = 8'h00, e1 = 8'h00, e2 = 8'h00;

  always #5 clk = ~clk;

  // Registered image ROM: 8'h1C everywhere, optionally transparent at address 0
  always @(posedge clk) rom_data <= (rom_mode && rom_addr == 12'd0) ? 8'hE3 : 8'h1C;

  bouncing_image_source dut (
    .CLK_IN(clk), .RESET_N(RESET_N), .xCoord(xCoord), .yCoord(yCoord), .MOVE_EN(MOVE_EN),
    .rom_addr(rom_addr), .rom_data(rom_data), .RGB_out(RGB_out), .HIT(HIT)
  );

  bouncing_image_source #(.H_ACTIVE(496)) dut_c (
    .CLK_IN(clk), .RESET_N(RESET_N), .xCoord(xCoord), .yCoord(yCoord), .MOVE_EN(MOVE_EN),
    .rom_addr(rom_addr_c), .rom_data(rom_data_c), .RGB_out(RGB_out_c), .HIT(HIT_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    xCoord = 10'd700; yCoord = 10'd500;
    repeat (3) @(posedge clk);
    #1;
    e0 = 8'h00; e1 = 8'h00; e2 = 8'h00;
  endtask

  // Checks the pixel driven three edges earlier, then drives a new coordinate
  task automatic step(input int x, input int y, input logic [7:0] e);
    @(posedge clk); #1;
    chk("rgb_pipe", 32'(RGB_out), 32'(e2));
    e2 = e1; e1 = e0; e0 = e;
    xCoord = 10'(x); yCoord = 10'(y);
  endtask

  // One edge after driving (x,y), rom_addr must equal exp
  task automatic probe(input string tag, input int x, input int y, input int exp, input bit on_c);
    xCoord = 10'(x); yCoord = 10'(y);
    @(posedge clk); #1;
    if (on_c) chk(tag, 32'(rom_addr_c), 32'(exp));
    else      chk(tag, 32'(rom_addr), 32'(exp));
  endtask

  task automatic do_tick(input int hold, output logic h1, output logic h1c,
                         output logic h2, output logic h2c);
    xCoord = 10'd0; yCoord = 10'd480;
    @(posedge clk); #1;
    h1 = HIT; h1c = HIT_c;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    xCoord = 10'd1;
    @(posedge clk); #1;
    h2 = HIT; h2c = HIT_c;
  endtask

  task automatic ax(inout int p, inout bit d, inout bit f, input int lim);
    if (!d) begin
      if (p + 1 >= lim) begin p = lim; d = 1'b1; f = 1'b1; end
      else p = p + 1;
    end else begin
      if (p <= 1) begin p = 0; d = 1'b0; f = 1'b1; end
      else p = p - 1;
    end
  endtask

  initial begin
    logic h1, h1c, h2, h2c;
    int mx, my, cx, cy, hits_m, hits_c;
    bit mdx, mdy, cdx, cdy, fm, fc;

    #12;
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_rgb", 32'(RGB_out), 0);
    chk("reset_hit", 32'(HIT), 0);
    chk("reset_rgb_c", 32'(RGB_out_c), 0);
    chk("reset_rom_addr_c", 32'(rom_addr_c), 0);
    #10 RESET_N = 1'b1;

    probe("addr_5_2", 5, 2, 133, 1'b0);

    // Image at origin, motion disabled
    settle();
    for (int y = 0; y < 50; y++)
      for (int x = 0; x < 70; x++)
        step(x, y, (x < 64 && y < 48) ? 8'h1C : 8'h00);
    step(639, 479, 8'h00);
    step(63, 47, 8'h1C);
    step(64, 47, 8'h00);
    step(63, 48, 8'h00);
    for (int i = 0; i < 3; i++) step(700, 500, 8'h00);

    // Transparent ROM value at address 0 shows the background
    settle();
    rom_mode = 1'b1;
    step(0, 0, 8'h00);
    step(1, 0, 8'h1C);
    step(0, 1, 8'h1C);
    for (int i = 0; i < 3; i++) step(700, 500, 8'h00);
    rom_mode = 1'b0;

    // Frozen tick leaves the image at the origin
    do_tick(1, h1, h1c, h2, h2c);
    chk("frozen_hit", 32'(h1), 0);
    probe("frozen_pos", 1, 0, 1, 1'b0);

    MOVE_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_tick(1, h1, h1c, h2, h2c);
      chk("early_hit", 32'(h1), 0);
    end
    probe("pos_3_3", 4, 3, 1, 1'b0);
    probe("pos_3_3_row", 3, 4, 64, 1'b0);

    // A held tick condition moves the image only once
    do_tick(4, h1, h1c, h2, h2c);
    probe("hold_pos_4_4", 5, 4, 1, 1'b0);

    mx = 4; my = 4; cx = 4; cy = 4;
    mdx = 0; mdy = 0; cdx = 0; cdy = 0;
    hits_m = 0; hits_c = 0;
    for (int n = 5; n <= 576; n++) begin
      fm = 0; fc = 0;
      ax(mx, mdx, fm, 576); ax(my, mdy, fm, 432);
      ax(cx, cdx, fc, 432); ax(cy, cdy, fc, 432);
      do_tick(1, h1, h1c, h2, h2c);
      chk("loop_hit", 32'(h1), 32'(fm));
      chk("loop_hit_c", 32'(h1c), 32'(fc));
      chk("loop_hit_pulse", 32'({h2, h2c}), 0);
      if (h1 === 1'b1) hits_m++;
      if (h1c === 1'b1) hits_c++;
    end
    chk("hit_count", 32'(hits_m), 2);
    chk("hit_count_c", 32'(hits_c), 1);
    probe("pos_576_288", 577, 288, 1, 1'b0);
    probe("pos_c_288_288", 289, 288, 1, 1'b1);

    do_tick(1, h1, h1c, h2, h2c);
    chk("after_flip_hit", 32'({h1, h1c}), 0);
    probe("pos_575_287", 576, 287, 1, 1'b0);
    probe("pos_c_287_287", 288, 287, 1, 1'b1);

    // Freeze: no motion or pulse, direction retained
    MOVE_EN = 1'b0;
    do_tick(1, h1, h1c, h2, h2c);
    chk("freeze_hit", 32'(h1), 0);
    probe("freeze_pos", 576, 287, 1, 1'b0);
    MOVE_EN = 1'b1;
    do_tick(1, h1, h1c, h2, h2c);
    probe("resume_pos", 575, 286, 1, 1'b0);
    probe("resume_pos_c", 287, 286, 1, 1'b1);

    // Mid-line reset clears outputs without waiting for a clock edge
    xCoord = 10'd600; yCoord = 10'd300;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_rgb", 32'(RGB_out), 32'h1C);
    #3 RESET_N = 1'b0;
    #1;
    chk("async_rgb", 32'(RGB_out), 0);
    chk("async_rom_addr", 32'(rom_addr), 0);
    chk("async_hit", 32'(HIT), 0);
    #2 RESET_N = 1'b1;
    probe("post_reset_pos", 1, 0, 1, 1'b0);
    do_tick(1, h1, h1c, h2, h2c);
    chk("post_reset_tick_hit", 32'(h1), 0);
    probe("post_reset_move", 2, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bouncing_image_source.md
Name: bouncing_image_source

Overview:
- Pixel source directly upstream of the VGA driver: consumes the driver's xCoord/yCoord and produces the 8-bit RGB332 pixel the driver drives onto the RGB pins.
- Overlays an IMG_W x IMG_H image, fetched from an external synchronous ROM, on a flat background colour.
- The image position bounces around the active area, moving once per frame during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- IMG_W, 64, image width in pixels, power of two
- IMG_H, 48, image height in lines
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- STEP, 1, pixels moved per frame on each axis, 1..15
- BG_COLOR, 8'h00, background colour (RGB332)
- TRANSPARENT, 8'hE3, ROM value rendered as background

Ports:
- CLK_IN  in  1  system clock, same clock as the VGA driver
- RESET_N  in  1  asynchronous active-low reset
- xCoord  in  10  driver's current horizontal count
- yCoord  in  10  driver's current vertical count
- MOVE_EN  in  1  1 = motion enabled; 0 = image frozen
- rom_addr  out  ADDR_W  image ROM read address
- rom_data  in  8  ROM data, valid one cycle after rom_addr (registered ROM)
- RGB_out  out  8  pixel colour; connects to the driver's RGB_in
- HIT  out  1  one-cycle pulse when a direction flips

Behaviour:
- Reset (async assert, sync release):
  - rom_addr=0, RGB_out=BG_COLOR, HIT=0.
  - pos_x=0, pos_y=0, dir_x=+, dir_y=+.
  - Pipeline valid flags cleared; tick edge detector cleared.
- Pipeline, 3-cycle fixed latency from coordinate to RGB_out:
  - Edge 1:
    - in_d1 <= (xCoord>=pos_x && xCoord<pos_x+IMG_W && yCoord>=pos_y && yCoord<pos_y+IMG_H).
    - rom_addr <= in ? (yCoord-pos_y)*IMG_W + (xCoord-pos_x) : 0. The multiply is a shift because IMG_W is a power of two.
  - Edge 2: ROM presents rom_data; in_d2 <= in_d1.
  - Edge 3: RGB_out <= (in_d2 && rom_data!=TRANSPARENT) ? rom_data : BG_COLOR.
  - Coordinates outside the active area are always "outside", because pos_x+IMG_W<=H_ACTIVE and pos_y+IMG_H<=V_ACTIVE are invariants.
  - The pipeline runs every cycle with no stall. Coordinates held for several cycles (pixel-enable clocking) produce repeated identical outputs.
- Frame tick:
  - cond = (xCoord==0 && yCoord==V_ACTIVE), i.e. the first blanking line.
  - tick = cond && !cond_prev, so it fires exactly once per frame regardless of how long the coordinates hold.
- Motion, evaluated only on tick with MOVE_EN=1; position registers change nowhere else, so there is no tearing inside the active area.
  - X moving +:
    - If pos_x+STEP >= H_ACTIVE-IMG_W: pos_x <= H_ACTIVE-IMG_W, dir_x <= -, flip.
    - Else pos_x <= pos_x+STEP.
  - X moving -:
    - If pos_x <= STEP: pos_x <= 0, dir_x <= +, flip.
    - Else pos_x <= pos_x-STEP.
  - Y: identical rule using V_ACTIVE-IMG_H.
  - Both axes update on the same tick. A corner hit flips both directions.
  - HIT=1 for exactly the cycle after a tick in which at least one axis flipped; otherwise 0.
- MOVE_EN=0 at tick: no position change, HIT stays 0, directions retained.
- Arithmetic: internal comparisons are 11 bits wide so pos+IMG_W never wraps.
- Reset mid-frame: outputs return to reset values immediately. The first tick after release moves the image from (0,0).

Test Plan:
- Reset, then scan a full 800x525 frame with MOVE_EN=0 and a ROM returning 8'h1C everywhere -> RGB_out=8'h1C for exactly 64x48 pixels at x 0..63, y 0..47, delayed 3 cycles; BG_COLOR everywhere else. Includes a check that xCoord=5,yCoord=2 gives rom_addr=133 one cycle later.
- ROM returns 8'hE3 at address 0 -> pixel (0,0) renders 8'h00 (transparent pixel shows background).
- MOVE_EN=1 for 3 frames, STEP=1 -> image origin at (3,3); HIT never asserts; position registers unchanged during active lines.
- Force pos_x=575, dir_x=+, STEP=1, then one tick -> pos_x=576, dir_x=-, HIT pulses exactly one cycle. Next tick -> pos_x=575.
- Force pos=(576,432), both dirs + -> single tick flips both axes with one HIT pulse; position stays (576,432), then (575,431) on the next tick.
- Hold xCoord=0,yCoord=480 for 4 cycles -> exactly one position update. Assert RESET_N low mid-line -> RGB_out=8'h00 and rom_addr=0 asynchronously, before the next edge.
